// File: rtl/sram_access_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sram_access_scheduler                                                  |
// | Single-port async SRAM sequencer: display reads have priority, two     |
// | write ports share round-robin, bounded read bursts, bus turnaround.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module sram_access_scheduler #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int RD_CYCLES    = 2,
  parameter int WR_CYCLES    = 2,
  parameter int MAX_RD_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr0_valid,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  output logic              o_wr0_ready,
  input  logic              i_wr1_valid,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  output logic              o_wr1_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int PH_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BC_W = $clog2(MAX_RD_BURST + 1);
  localparam logic [PH_W-1:0] C_RD_LAST   = PH_W'(RD_CYCLES - 1);
  localparam logic [PH_W-1:0] C_WR_LAST   = PH_W'(WR_CYCLES - 1);
  localparam logic [BC_W-1:0] C_BURST_MAX = BC_W'(MAX_RD_BURST);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [BC_W-1:0]   r_burst;
  logic              r_rr;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_be_n;

  logic w_idle;
  logic w_any_wr;
  logic w_burst_full;
  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_wr_sel;

  // Readies are gated by reset so nothing is accepted while the block is held.
  assign w_idle       = (r_state == S_IDLE) && i_rst_n;
  assign w_any_wr     = i_wr0_valid | i_wr1_valid;
  assign w_burst_full = (r_burst == C_BURST_MAX) && w_any_wr;
  assign w_gnt_rd     = w_idle && i_rd_valid && !w_burst_full;
  assign w_gnt_wr     = w_idle && w_any_wr && !w_gnt_rd;
  assign w_wr_sel     = (i_wr0_valid && i_wr1_valid) ? r_rr : i_wr1_valid;

  assign o_rd_ready  = w_gnt_rd;
  assign o_wr0_ready = w_gnt_wr & ~w_wr_sel;
  assign o_wr1_ready = w_gnt_wr & w_wr_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_burst    <= '0;
      r_rr       <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_addr     <= '0;
      r_dq       <= '0;
      r_dq_oe    <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_be_n     <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_phase <= '0;
          if (w_gnt_rd) begin
            r_state <= S_READ;
            r_addr  <= i_rd_addr;
            r_ce_n  <= 1'b0;
            r_oe_n  <= 1'b0;
            r_be_n  <= 1'b0;
            if (!w_any_wr)
              r_burst <= '0;
            else if (r_burst != C_BURST_MAX)
              r_burst <= r_burst + 1'b1;
          end else if (w_gnt_wr) begin
            r_state <= S_WRITE;
            r_addr  <= w_wr_sel ? i_wr1_addr : i_wr0_addr;
            r_dq    <= w_wr_sel ? i_wr1_data : i_wr0_data;
            r_dq_oe <= 1'b1;
            r_ce_n  <= 1'b0;
            r_we_n  <= 1'b0;
            r_be_n  <= 1'b0;
            r_rr    <= ~w_wr_sel;
            r_burst <= '0;
          end
        end
        S_READ: begin
          if (r_phase == C_RD_LAST) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_rd_data  <= i_sram_dq;
            r_rd_valid <= 1'b1;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_be_n     <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_phase == C_WR_LAST) begin
            r_state <= S_TURN;
            r_phase <= '0;
            r_we_n  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_TURN: begin
          // Data is still driven this cycle so the SRAM sees hold time after WE_N rises.
          r_state <= S_IDLE;
          r_dq_oe <= 1'b0;
          r_ce_n  <= 1'b1;
          r_be_n  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_data    = r_rd_data;
  assign o_sram_addr  = r_addr;
  assign o_sram_dq    = r_dq;
  assign o_sram_dq_oe = r_dq_oe;
  assign o_sram_ce_n  = r_ce_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_lb_n  = r_be_n;
  assign o_sram_ub_n  = r_be_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sram_access_scheduler                                               |
// | Directed scenarios plus random traffic against a transaction model.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_sram_access_scheduler;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int RD   = 2;
  localparam int WR   = 2;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst_n;
  logic          rd_valid, rd_ready, rdv;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [AW-1:0] wr0_addr, wr1_addr, sram_addr;
  logic [DW-1:0] wr0_data, wr1_data, sram_dq_o, sram_dq_i;
  logic          dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  int n_total = 0;
  int n_bad   = 0;
  logic m_rr  = 1'b0;
  int   m_burst = 0;

  logic [DW-1:0] chip   [int unsigned];
  logic [DW-1:0] refmem [int unsigned];

  typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;

  sram_access_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD), .WR_CYCLES(WR), .MAX_RD_BURST(MAXB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
    .o_rd_valid(rdv), .o_rd_data(rd_data),
    .i_wr0_valid(wr0_valid), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data), .o_wr0_ready(wr0_ready),
    .i_wr1_valid(wr1_valid), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data), .o_wr1_ready(wr1_ready),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq_o), .o_sram_dq_oe(dq_oe), .i_sram_dq(sram_dq_i),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [DW-1:0] chip_rd(input logic [AW-1:0] a);
    return chip.exists(32'(a)) ? chip[32'(a)] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return refmem.exists(32'(a)) ? refmem[32'(a)] : init_word(a);
  endfunction

  // Behavioural SRAM chip: stores on WE_N low, drives data while OE_N low, noise otherwise.
  always @(negedge clk) begin
    if (rst_n && !ce_n && !we_n && dq_oe) chip[32'(sram_addr)] = sram_dq_o;
    sram_dq_i = (!ce_n && !oe_n) ? chip_rd(sram_addr) : 16'($urandom);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    rd_valid = 1'b1; wr0_valid = 1'b1; wr1_valid = 1'b1;
    rd_addr = '1; wr0_addr = '1; wr1_addr = '1; wr0_data = '1; wr1_data = '1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
      n_bad++; $display("FAIL reset_strobes got=%b exp=11111", {ce_n, oe_n, we_n, lb_n, ub_n});
    end
    n_total++;
    if ({dq_oe, rd_ready, wr0_ready, wr1_ready, rdv} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=00000", {dq_oe, rd_ready, wr0_ready, wr1_ready, rdv});
    end
    n_total++;
    if ({sram_addr, sram_dq_o, rd_data} !== '0) begin
      n_bad++; $display("FAIL reset_data addr=%h dq=%h rd=%h exp=0", sram_addr, sram_dq_o, rd_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rd_valid = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ce_n, rd_ready, wr0_ready, wr1_ready} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_idle got=%b exp=1000", {ce_n, rd_ready, wr0_ready, wr1_ready});
    end
    m_rr = 1'b0; m_burst = 0;
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    wr0_valid = 1'b1; wr0_addr = 20'h00100; wr0_data = 16'hABCD;
    @(negedge clk);
    n_total++;
    if ({rd_ready, wr0_ready, wr1_ready, ce_n} !== 4'b0101) begin
      n_bad++; $display("FAIL wr_grant got=%b exp=0101", {rd_ready, wr0_ready, wr1_ready, ce_n});
    end
    @(posedge clk); #1; wr0_valid = 1'b0;
    for (int k = 1; k <= WR; k++) begin
      @(negedge clk);
      n_total++;
      if ({ce_n, oe_n, we_n, lb_n, ub_n, dq_oe} !== 6'b010001 || sram_addr !== 20'h00100 || sram_dq_o !== 16'hABCD) begin
        n_bad++; $display("FAIL wr_phase%0d strobes=%b addr=%h dq=%h exp=010001/00100/abcd", k,
                          {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, sram_addr, sram_dq_o);
      end
    end
    @(negedge clk);
    n_total++;
    if ({ce_n, oe_n, we_n, dq_oe} !== 4'b0111 || sram_dq_o !== 16'hABCD || wr0_ready !== 1'b0) begin
      n_bad++; $display("FAIL wr_turn strobes=%b dq=%h exp=0111/abcd", {ce_n, oe_n, we_n, dq_oe}, sram_dq_o);
    end
    @(negedge clk);
    n_total++;
    if ({ce_n, oe_n, we_n, dq_oe} !== 4'b1110) begin
      n_bad++; $display("FAIL wr_idle strobes=%b exp=1110", {ce_n, oe_n, we_n, dq_oe});
    end
    m_rr = 1'b1; m_burst = 0;
  endtask

  task automatic test_single_read();
    chip[32'h12345] = 16'h5A5A;
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_addr = 20'h12345;
    @(negedge clk);
    n_total++;
    if ({rd_ready, wr0_ready, wr1_ready} !== 3'b100) begin
      n_bad++; $display("FAIL rd_grant got=%b exp=100", {rd_ready, wr0_ready, wr1_ready});
    end
    @(posedge clk); #1; rd_valid = 1'b0;
    for (int k = 1; k <= RD; k++) begin
      @(negedge clk);
      n_total++;
      if ({ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, rdv} !== 7'b0010000 || sram_addr !== 20'h12345) begin
        n_bad++; $display("FAIL rd_phase%0d strobes=%b addr=%h exp=0010000/12345", k,
                          {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, rdv}, sram_addr);
      end
    end
    @(negedge clk);
    n_total++;
    if (rdv !== 1'b1 || rd_data !== 16'h5A5A || oe_n !== 1'b1) begin
      n_bad++; $display("FAIL rd_result valid=%b data=%h oe_n=%b exp=1/5a5a/1", rdv, rd_data, oe_n);
    end
    @(negedge clk);
    n_total++;
    if (rdv !== 1'b0 || rd_data !== 16'h5A5A) begin
      n_bad++; $display("FAIL rd_hold valid=%b data=%h exp=0/5a5a", rdv, rd_data);
    end
    m_burst = 0;
  endtask

  task automatic test_alternating();
    int last = 0;
    int ngr = 0;
    logic prev = 1'b0;
    logic sel, exp_sel;
    @(posedge clk); #1;
    wr0_valid = 1'b1; wr0_addr = 20'h00200; wr0_data = 16'h1111;
    wr1_valid = 1'b1; wr1_addr = 20'h00300; wr1_data = 16'h2222;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      n_total++;
      if (wr0_ready && wr1_ready) begin
        n_bad++; $display("FAIL alt_both cycle=%0d got=11 exp=one_hot", c);
      end
      if (wr0_ready || wr1_ready) begin
        sel = wr1_ready;
        exp_sel = (ngr == 0) ? m_rr : ~prev;
        n_total++;
        if (sel !== exp_sel) begin
          n_bad++; $display("FAIL alt_order grant#%0d got=wr%0d exp=wr%0d", ngr, sel, exp_sel);
        end
        if (ngr > 0) begin
          n_total++;
          if (c - last != WR + 2) begin
            n_bad++; $display("FAIL alt_spacing grant#%0d got=%0d exp=%0d", ngr, c - last, WR + 2);
          end
        end
        last = c; prev = sel; ngr++;
        m_rr = ~sel;
      end
    end
    n_total++;
    if (ngr != 6) begin
      n_bad++; $display("FAIL alt_count got=%0d exp=6", ngr);
    end
    @(posedge clk); #1; wr0_valid = 1'b0; wr1_valid = 1'b0;
    repeat (5) @(negedge clk);
    m_burst = 0;
  endtask

  task automatic test_read_burst();
    // Expected grants: four reads, then the starved write, then reads again.
    logic exp_kind [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_gap  [7] = '{0, RD + 1, RD + 1, RD + 1, RD + 1, WR + 2, RD + 1};
    int ngr = 0;
    int last = 0;
    logic kind;
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_addr = 20'h00040;
    wr1_valid = 1'b1; wr1_addr = 20'h00500; wr1_data = 16'h7777;
    for (int c = 0; c < 30 && ngr < 7; c++) begin
      @(negedge clk);
      if (rd_ready || wr0_ready || wr1_ready) begin
        kind = wr1_ready;
        n_total++;
        if (kind !== exp_kind[ngr] || wr0_ready !== 1'b0 || (ngr > 0 && c - last != exp_gap[ngr])) begin
          n_bad++; $display("FAIL burst grant#%0d kind=%b gap=%0d exp kind=%b gap=%0d", ngr, kind,
                            c - last, exp_kind[ngr], exp_gap[ngr]);
        end
        last = c; ngr++;
      end
      @(posedge clk); #1;
      if (kind === 1'b1) wr1_valid = 1'b0;
      if (ngr == 7) rd_valid = 1'b0;
    end
    n_total++;
    if (ngr != 7) begin
      n_bad++; $display("FAIL burst_count got=%0d exp=7", ngr);
    end
    rd_valid = 1'b0; wr1_valid = 1'b0;
    repeat (6) @(negedge clk);
    m_rr = 1'b0; m_burst = 0;
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    wr0_valid = 1'b1; wr0_addr = 20'h00400; wr0_data = 16'h9999;
    @(negedge clk);
    n_total++;
    if (wr0_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_wr_grant got=%b exp=1", wr0_ready);
    end
    @(posedge clk); #1; wr0_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (we_n !== 1'b0) begin
      n_bad++; $display("FAIL rst_wr_active we_n=%b exp=0", we_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({we_n, dq_oe, oe_n, ce_n} !== 4'b1011) begin
      n_bad++; $display("FAIL rst_async got=%b exp=1011", {we_n, dq_oe, oe_n, ce_n});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr0_valid = 1'b1; wr0_addr = 20'h00410; wr0_data = 16'h0101;
    wr1_valid = 1'b1; wr1_addr = 20'h00420; wr1_data = 16'h0202;
    @(negedge clk);
    n_total++;
    if ({rd_ready, wr0_ready, wr1_ready} !== 3'b010) begin
      n_bad++; $display("FAIL rst_rr got=%b exp=010", {rd_ready, wr0_ready, wr1_ready});
    end
    @(posedge clk); #1; wr0_valid = 1'b0; wr1_valid = 1'b0;
    repeat (5) @(negedge clk);
    m_rr = 1'b1; m_burst = 0;
  endtask

  task automatic test_random(input int ncyc);
    rd_exp_t  rq[$];
    int       busy_until = 0;
    int       g_cyc = 0;
    logic     g_wr = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_data = '0;
    logic [3:0] es;
    logic [2:0] exp_rdy, got_rdy;
    logic     any_wr, sel, exp_v;
    int       o;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      o = cyc - g_cyc;
      if (cyc >= busy_until) es = 4'b1110;
      else if (!g_wr)        es = 4'b0010;
      else if (o <= WR)      es = 4'b0101;
      else                   es = 4'b0111;
      n_total++;
      if ({ce_n, oe_n, we_n, dq_oe} !== es) begin
        n_bad++; $display("FAIL rnd_strobes cyc=%0d got=%b exp=%b", cyc, {ce_n, oe_n, we_n, dq_oe}, es);
      end
      if (cyc < busy_until) begin
        n_total++;
        if (sram_addr !== g_addr || (g_wr && sram_dq_o !== g_data)) begin
          n_bad++; $display("FAIL rnd_bus cyc=%0d addr=%h dq=%h exp=%h/%h", cyc, sram_addr, sram_dq_o, g_addr, g_data);
        end
      end
      exp_rdy = 3'b000;
      if (cyc >= busy_until) begin
        any_wr = wr0_valid | wr1_valid;
        if (rd_valid && !(m_burst == MAXB && any_wr)) begin
          exp_rdy = 3'b100;
          m_burst = any_wr ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
          rq.push_back('{cyc + RD + 1, ref_rd(rd_addr)});
          busy_until = cyc + RD + 1; g_cyc = cyc; g_wr = 1'b0; g_addr = rd_addr;
        end else if (any_wr) begin
          sel = (wr0_valid && wr1_valid) ? m_rr : wr1_valid;
          exp_rdy = sel ? 3'b001 : 3'b010;
          g_addr = sel ? wr1_addr : wr0_addr;
          g_data = sel ? wr1_data : wr0_data;
          refmem[32'(g_addr)] = g_data;
          m_rr = ~sel; m_burst = 0;
          busy_until = cyc + WR + 2; g_cyc = cyc; g_wr = 1'b1;
        end
      end
      got_rdy = {rd_ready, wr0_ready, wr1_ready};
      n_total++;
      if (got_rdy !== exp_rdy) begin
        n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, got_rdy, exp_rdy);
      end
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      n_total++;
      if (rdv !== exp_v || (exp_v && rd_data !== rq[0].data)) begin
        n_bad++; $display("FAIL rnd_rdata cyc=%0d valid=%b data=%h exp=%b/%h", cyc, rdv, rd_data, exp_v,
                          exp_v ? rq[0].data : 16'h0);
      end
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      @(posedge clk); #1;
      if (got_rdy[2]) rd_valid = 1'b0;
      if (got_rdy[1]) wr0_valid = 1'b0;
      if (got_rdy[0]) wr1_valid = 1'b0;
      if (cyc < ncyc - 20) begin
        if (!rd_valid && $urandom_range(0, 99) < 40) begin
          rd_valid = 1'b1; rd_addr = 20'($urandom_range(0, 31));
        end
        if (!wr0_valid && $urandom_range(0, 99) < 25) begin
          wr0_valid = 1'b1; wr0_addr = 20'($urandom_range(0, 31)); wr0_data = 16'($urandom);
        end
        if (!wr1_valid && $urandom_range(0, 99) < 25) begin
          wr1_valid = 1'b1; wr1_addr = 20'($urandom_range(0, 31)); wr1_data = 16'($urandom);
        end
      end
    end
    n_total++;
    if (rq.size() != 0 || rd_valid || wr0_valid || wr1_valid) begin
      n_bad++; $display("FAIL rnd_drain pending_reads=%0d req=%b exp=0/000", rq.size(), {rd_valid, wr0_valid, wr1_valid});
    end
  endtask

  initial begin
    sram_dq_i = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_alternating();
    test_read_burst();
    test_reset_mid_write();
    test_random(1500);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
